// File: rtl/cpu_run_control.sv
// cpu_run_control: sequences the core through a timed reset, a run window and a halt/timeout stop.
module cpu_run_control #(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES = 1000,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   HALT_REQ,
  output logic                   CPU_RESET,
  output logic                   RUN,
  output logic                   DONE,
  output logic                   TIMEOUT,
  output logic [COUNT_WIDTH-1:0] CYCLE_COUNT
);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_HALTED, S_TIMED_OUT} state_t;
  localparam logic [COUNT_WIDTH-1:0] MAX = COUNT_WIDTH'(MAX_CYCLES);
  localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES);
  state_t state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, count_inc;
  logic cpu_reset_q, cpu_reset_d, run_q, run_d, done_q, done_d, timeout_q, timeout_d;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q + 8'd1;
    count_d = count_q;
    count_inc = &count_q ? count_q : count_q + COUNT_WIDTH'(1);
    case (state_q)
      S_IDLE, S_HALTED, S_TIMED_OUT: if (START) begin
        state_d = S_HOLD;
        hold_d = '0;
        count_d = '0;
      end
      S_HOLD: if (hold_q == HOLD_LAST) state_d = S_RUN;
      S_RUN: begin
        count_d = count_inc;
        state_d = HALT_REQ ? S_HALTED :
                  (MAX_CYCLES != 0 && count_inc == MAX) ? S_TIMED_OUT : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    // outputs are decoded from the next state so they register alongside it
    cpu_reset_d = state_d == S_IDLE || state_d == S_HOLD;
    run_d = state_d == S_RUN;
    done_d = state_d == S_HALTED;
    timeout_d = state_d == S_TIMED_OUT;
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      count_q <= '0;
      cpu_reset_q <= 1'b1;
      run_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      count_q <= count_d;
      cpu_reset_q <= cpu_reset_d;
      run_q <= run_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
    end
  end
  assign CPU_RESET = cpu_reset_q;
  assign RUN = run_q;
  assign DONE = done_q;
  assign TIMEOUT = timeout_q;
  assign CYCLE_COUNT = count_q;
endmodule

// File: tb/tb_cpu_run_control.sv
// tb_cpu_run_control: three parameterisations driven in parallel against a phase-level reference model.
module tb_cpu_run_control;
  localparam int RC = 4;
  localparam int IDLE = 0, HOLD = 1, RUNNING = 2, HALTED = 3, TIMED = 4;
  logic CLOCK = 1'b0, RESET = 1'b1, START = 1'b1, HALT_REQ = 1'b0;
  always #5 CLOCK = ~CLOCK;
  logic a_cr, a_run, a_done, a_to, b_cr, b_run, b_done, b_to, c_cr, c_run, c_done, c_to;
  logic [31:0] a_cnt, b_cnt;
  logic [3:0] c_cnt;
  cpu_run_control #(.RESET_CYCLES(RC), .MAX_CYCLES(1000), .COUNT_WIDTH(32)) u_a (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .HALT_REQ(HALT_REQ),
    .CPU_RESET(a_cr), .RUN(a_run), .DONE(a_done), .TIMEOUT(a_to), .CYCLE_COUNT(a_cnt));
  cpu_run_control #(.RESET_CYCLES(RC), .MAX_CYCLES(20), .COUNT_WIDTH(32)) u_b (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .HALT_REQ(HALT_REQ),
    .CPU_RESET(b_cr), .RUN(b_run), .DONE(b_done), .TIMEOUT(b_to), .CYCLE_COUNT(b_cnt));
  cpu_run_control #(.RESET_CYCLES(RC), .MAX_CYCLES(0), .COUNT_WIDTH(4)) u_c (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .HALT_REQ(HALT_REQ),
    .CPU_RESET(c_cr), .RUN(c_run), .DONE(c_done), .TIMEOUT(c_to), .CYCLE_COUNT(c_cnt));
  logic [35:0] obs [3];
  assign obs[0] = {a_cr, a_run, a_done, a_to, a_cnt};
  assign obs[1] = {b_cr, b_run, b_done, b_to, b_cnt};
  assign obs[2] = {c_cr, c_run, c_done, c_to, 28'd0, c_cnt};
  int checks = 0, errors = 0;
  int limit [3] = '{1000, 20, 0};
  longint sat [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int ph [3] = '{IDLE, IDLE, IDLE};
  int wait_n [3];
  longint cnt [3] = '{0, 0, 0};
  logic [35:0] exp_v [3];
  always @(posedge CLOCK) begin
    for (int i = 0; i < 3; i++) begin
      if (RESET) begin
        ph[i] = IDLE;
        cnt[i] = 0;
      end else if (ph[i] == HOLD) begin
        wait_n[i]--;
        if (wait_n[i] == 0) ph[i] = RUNNING;
      end else if (ph[i] == RUNNING) begin
        if (cnt[i] < sat[i]) cnt[i]++;
        if (HALT_REQ) ph[i] = HALTED;
        else if (limit[i] != 0 && cnt[i] == longint'(limit[i])) ph[i] = TIMED;
      end else if (START) begin
        ph[i] = HOLD;
        wait_n[i] = RC + 1;
        cnt[i] = 0;
      end
      exp_v[i] = {ph[i] <= HOLD, ph[i] == RUNNING, ph[i] == HALTED, ph[i] == TIMED, 32'(cnt[i])};
    end
  end
  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask
  task automatic test_reset;
    RESET = 1'b1; START = 1'b1; HALT_REQ = 1'b0;
    repeat (2) begin
      tick;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== {4'b1000, 32'd0}) begin
          errors++; $display("FAIL reset inst%0d got %h exp %h", i, obs[i], {4'b1000, 32'd0});
        end
      end
    end
    RESET = 1'b0; START = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_v[i] || obs[i][35:32] !== 4'b1000) begin
        errors++; $display("FAIL reset_idle inst%0d got %h exp %h", i, obs[i], exp_v[i]);
      end
    end
  endtask
  task automatic test_nominal;
    int runs;
    START = 1'b1; tick; START = 1'b0;
    for (int k = 1; k <= RC; k++) begin
      tick;
      checks++;
      if ({a_cr, a_run} !== 2'b10) begin
        errors++; $display("FAIL nom_hold edge%0d got cr/run %b%b exp 10", k, a_cr, a_run);
      end
    end
    tick;
    checks++;
    if ({a_cr, a_run} !== 2'b01 || a_cnt !== 32'd0) begin
      errors++; $display("FAIL nom_run_start got cr/run %b%b cnt %0d exp 01 cnt 0", a_cr, a_run, a_cnt);
    end
    runs = 1;
    repeat (9) begin
      tick;
      runs += int'(a_run);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++; $display("FAIL nom_model inst%0d got %h exp %h", i, obs[i], exp_v[i]);
        end
      end
    end
    HALT_REQ = 1'b1; tick; HALT_REQ = 1'b0;
    checks++;
    if (runs !== 10) begin
      errors++; $display("FAIL nom_run_len got %0d exp 10", runs);
    end
    checks++;
    if ({a_cr, a_run, a_done, a_to} !== 4'b0010 || a_cnt !== 32'd10) begin
      errors++; $display("FAIL nom_done got flags %b cnt %0d exp 0010 cnt 10", {a_cr, a_run, a_done, a_to}, a_cnt);
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_v[i] || obs[i][33] !== 1'b1) begin
        errors++; $display("FAIL nom_done_stable inst%0d got %h exp %h", i, obs[i], exp_v[i]);
      end
    end
  endtask
  task automatic test_timeout;
    int runs;
    bit seen;
    START = 1'b1; tick; START = 1'b0;
    checks++;
    if (a_done !== 1'b0 || a_cnt !== 32'd0 || a_cr !== 1'b1) begin
      errors++; $display("FAIL restart got done %b cnt %0d cr %b exp 0 0 1", a_done, a_cnt, a_cr);
    end
    runs = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick;
      runs += int'(b_run);
      seen = b_to;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++; $display("FAIL to_model inst%0d got %h exp %h", i, obs[i], exp_v[i]);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL to_wait got no TIMEOUT within 100 cycles exp TIMEOUT");
    end
    checks++;
    if (runs !== 20 || b_done !== 1'b0 || b_cnt !== 32'd20) begin
      errors++; $display("FAIL to_result got runs %0d done %b cnt %0d exp 20 0 20", runs, b_done, b_cnt);
    end
    checks++;
    if (c_cnt !== 4'hF || c_run !== 1'b1) begin
      errors++; $display("FAIL saturate got cnt %h run %b exp f 1", c_cnt, c_run);
    end
    HALT_REQ = 1'b1; tick; HALT_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_v[i]) begin
        errors++; $display("FAIL to_halt inst%0d got %h exp %h", i, obs[i], exp_v[i]);
      end
    end
  endtask
  task automatic test_simultaneous;
    START = 1'b1; tick; START = 1'b0;
    HALT_REQ = 1'b1;
    repeat (RC + 1) tick;
    HALT_REQ = 1'b0;
    checks++;
    if ({b_run, b_done} !== 2'b10 || b_cnt !== 32'd0) begin
      errors++; $display("FAIL hold_ignore got run/done %b%b cnt %0d exp 10 cnt 0", b_run, b_done, b_cnt);
    end
    repeat (19) tick;
    HALT_REQ = 1'b1; tick; HALT_REQ = 1'b0;
    checks++;
    if ({b_run, b_done, b_to} !== 3'b010 || b_cnt !== 32'd20) begin
      errors++; $display("FAIL simul got run/done/to %b cnt %0d exp 010 cnt 20", {b_run, b_done, b_to}, b_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_v[i]) begin
        errors++; $display("FAIL simul_model inst%0d got %h exp %h", i, obs[i], exp_v[i]);
      end
    end
  endtask
  task automatic test_mid_reset;
    START = 1'b1; tick; START = 1'b0;
    repeat (RC + 1) tick;
    repeat (6) tick;
    checks++;
    if (a_run !== 1'b1 || a_cnt !== 32'd6) begin
      errors++; $display("FAIL mid_pre got run %b cnt %0d exp 1 6", a_run, a_cnt);
    end
    RESET = 1'b1; START = 1'b1; HALT_REQ = 1'b1; tick;
    RESET = 1'b0; START = 1'b0; HALT_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== {4'b1000, 32'd0}) begin
        errors++; $display("FAIL mid_reset inst%0d got %h exp %h", i, obs[i], {4'b1000, 32'd0});
      end
    end
  endtask
  task automatic test_back_to_back;
    int streak, starts;
    bit prev_run;
    streak = 0; starts = 0; prev_run = 0;
    START = 1'b1;
    repeat (200) begin
      tick;
      HALT_REQ = a_run && ($urandom_range(0, 3) == 0);
      if (a_run && !prev_run) begin
        starts++;
        checks++;
        if (streak !== RC + 1) begin
          errors++; $display("FAIL b2b_hold got %0d reset cycles exp %0d", streak, RC + 1);
        end
      end
      streak = a_cr ? streak + 1 : 0;
      prev_run = a_run;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++; $display("FAIL b2b_model inst%0d got %h exp %h", i, obs[i], exp_v[i]);
        end
      end
    end
    START = 1'b0; HALT_REQ = 1'b0;
    checks++;
    if (starts < 2) begin
      errors++; $display("FAIL b2b_runs got %0d runs exp at least 2", starts);
    end
  endtask
  task automatic test_random;
    repeat (1500) begin
      RESET = $urandom_range(0, 149) == 0;
      START = $urandom_range(0, 7) == 0;
      HALT_REQ = $urandom_range(0, 15) == 0;
      tick;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_v[i] || (obs[i][33] && obs[i][32])) begin
          errors++; $display("FAIL random inst%0d got %h exp %h", i, obs[i], exp_v[i]);
        end
      end
    end
    RESET = 1'b0; START = 1'b0; HALT_REQ = 1'b0;
  endtask
  initial begin
    test_reset;
    test_nominal;
    test_timeout;
    test_simultaneous;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
